seg7_scan_controller: RTL and testbench

Time-multiplexed scan controller for the board's common-anode 7-segment display. It divides clk_in down to a per-digit slot rate and walks a digit index across NUM_DIGITS digits, driving one anode at a time. It inserts a blanking interval at the start of every slot to suppress ghosting, and applies leading-zero blanking and a per-digit enable mask. New values are latched into a pending register and transferred to the displayed register only at a frame boundary, so no frame ever mixes old and new digits.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_slot_timer.sv | 34 +++
 rtl/seg7_scan_controller.sv | 130 +++++++++++++
 tb/tb_seg7_scan_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, constants and glyph decoding for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return ~seg;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter: counts 0..DIV-1 and flags the wrap and the blanking window.
module seg7_slot_timer #(
    parameter int DIV          = 10,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk_in,
    input  logic reset,
    output logic slot_wrap,
    output logic blank_last,
    output logic in_blank
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;

    assign slot_wrap  = (slot_cnt_q == CNT_LAST);
    // blank_last lets the FSM enter SHOW in the same cycle the count reaches BLANK_CYCLES.
    assign blank_last = (slot_cnt_q == BLANK_LAST);
    assign in_blank   = (slot_cnt_q < BLANK_END);

    always_comb begin
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (reset) slot_cnt_q <= '0;
        else       slot_cnt_q <= slot_cnt_d;
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed common-anode display scanner with per-slot blanking, leading-zero
// suppression and frame-aligned shadowing of the displayed value.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int SCAN_FREQ    = 500,
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   anodes_n,
    output logic [6:0]              segments_n,
    output logic                    dp_n,
    output logic                    frame_done,
    output scan_state_t             dbg_state
);

    localparam int DIV   = CLK_FREQ / SCAN_FREQ;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic slot_wrap, blank_last, in_blank;

    seg7_slot_timer #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk_in     (clk_in),
        .reset      (reset),
        .slot_wrap  (slot_wrap),
        .blank_last (blank_last),
        .in_blank   (in_blank)
    );

    scan_state_t               state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   pend_val_q, act_val_q;
    logic [NUM_DIGITS-1:0]     pend_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0]     anodes_q, anodes_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      frame_done_q;
    logic                      frame_wrap, upper_zero, lead_zero, lit;
    logic [3:0]                cur_nib;

    assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    assign dbg_state  = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (blank_last) state_d = SHOW;
            SHOW:    if (slot_wrap)  state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (frame_wrap)     idx_d = '0;
        else if (slot_wrap) idx_d = idx_q + 1'b1;
    end

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_q) && act_val_q[4*j +: 4] != 4'h0) upper_zero = 1'b0;
        end
    end

    assign cur_nib   = act_val_q[4*idx_q +: 4];
    assign lead_zero = lz_blank && (idx_q != '0) && upper_zero;
    assign lit       = (state_q == SHOW) && !in_blank && digit_en[idx_q] && !lead_zero;

    always_comb begin
        anodes_d = '1;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        if (lit) begin
            anodes_d[idx_q] = 1'b0;
            seg_d           = hex_to_seg_n(cur_nib);
            dp_d            = ~act_dp_q[idx_q];
        end
    end

    // Transfer reads the old pending value, so a load on the wrap cycle waits a frame.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= BLANK;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            anodes_q     <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            anodes_q     <= anodes_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_wrap;
            if (load) begin
                pend_val_q <= value_in;
                pend_dp_q  <= dp_in;
            end
            if (frame_wrap) begin
                act_val_q <= pend_val_q;
                act_dp_q  <= pend_dp_q;
            end
        end
    end

    assign anodes_n   = anodes_q;
    assign segments_n = seg_q;
    assign dp_n       = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller: 4 digits, 10-cycle slots, 2 blank cycles.
module tb_seg7_scan_controller;
    import seg7_pkg::*;

    localparam int N     = 4;
    localparam int DIVB  = 10;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIVB;
    localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

    logic        clk_in   = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in    = '0;
    logic [3:0]  digit_en = 4'hF;
    logic        lz_blank = 1'b0;
    logic        load     = 1'b0;
    logic [3:0]  anodes_n;
    logic [6:0]  segments_n;
    logic        dp_n;
    logic        frame_done;
    scan_state_t dbg_state;

    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic [15:0] act_v = '0, pend_v = '0;
    logic [3:0]  act_dp = '0, pend_dp = '0;

    seg7_scan_controller #(
        .CLK_FREQ     (1000),
        .SCAN_FREQ    (100),
        .NUM_DIGITS   (N),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .load       (load),
        .anodes_n   (anodes_n),
        .segments_n (segments_n),
        .dp_n       (dp_n),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Active-high gfedcba glyphs.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    function automatic logic [11:0] exp_digit(input int d);
        logic [3:0] nib;
        logic       dark;
        nib  = act_v[4*d +: 4];
        dark = !digit_en[d] || (lz_blank && d > 0 && (act_v >> (4*d)) == 16'h0);
        if (dark) return DARK;
        return {~(4'b0001 << d), ~glyph(nib), ~act_dp[d]};
    endfunction

    task automatic push_frame();
        for (int d = 0; d < N; d++) exp_q.push_back(exp_digit(d));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!frame_done && n < 2*FRAME);
        chk("frame_wait", {15'b0, frame_done}, 16'h1);
        tick(1);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
        value_in = v;
        dp_in    = dp;
        load     = 1'b1;
        tick(1);
        load     = 1'b0;
        pend_v   = v;
        pend_dp  = dp;
    endtask

    task automatic new_frame();
        act_v  = pend_v;
        act_dp = pend_dp;
        push_frame();
    endtask

    // Output monitor: c counts cycles since reset release; outputs lag state by one cycle.
    initial begin : monitor
        int          oc;
        int          c;
        int          ph;
        logic [11:0] obs;
        logic [11:0] cap;
        logic [11:0] e;
        oc  = 0;
        cap = DARK;
        forever begin
            @(negedge clk_in);
            if (!mon_en) begin
                oc = 0;
            end else begin
                c = oc;
                oc++;
                obs = {anodes_n, segments_n, dp_n};
                if (c == 0) begin
                    chk("reset_outputs", {4'b0, obs}, {4'b0, DARK});
                    chk("reset_frame_done", {15'b0, frame_done}, 16'h0);
                end else begin
                    ph = (c - 1) % DIVB;
                    chk("frame_done", {15'b0, frame_done}, {15'b0, (c % FRAME) == 0});
                    if (ph < BLK)       chk("blank_cycle", {4'b0, obs}, {4'b0, DARK});
                    else if (ph == BLK) cap = obs;
                    else                chk("slot_stable", {4'b0, obs}, {4'b0, cap});
                    if (ph == DIVB - 1) begin
                        chk("queue_has_entry", {15'b0, exp_q.size() > 0}, 16'h1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("slot_value", {4'b0, cap}, {4'b0, e});
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        int n;
        reset = 1'b1;
        tick(3);
        chk("reset_state", {15'b0, dbg_state}, {15'b0, BLANK});
        reset  = 1'b0;
        mon_en = 1'b1;
        push_frame();
        tick(5);
        load_val(16'h12AF, 4'b0000);

        wait_frame(); new_frame();
        tick(8);
        load_val(16'h0030, 4'b0000);

        wait_frame(); lz_blank = 1'b1; new_frame();

        wait_frame(); lz_blank = 1'b0; new_frame();
        tick(3);
        load_val(16'h0000, 4'b0000);

        wait_frame(); lz_blank = 1'b1; new_frame();
        tick(3);
        load_val(16'h9C4E, 4'b0001);

        wait_frame(); lz_blank = 1'b0; digit_en = 4'b1010; new_frame();
        tick(10);
        load_val(16'h1111, 4'b0000);
        tick(1);
        load_val(16'h2222, 4'b0000);

        wait_frame(); digit_en = 4'hF; new_frame();
        tick(FRAME - 2);
        value_in = 16'h7777;
        load     = 1'b1;
        tick(1);
        load     = 1'b0;
        tick(1);
        new_frame();
        pend_v  = 16'h7777;
        pend_dp = 4'b0000;

        wait_frame(); new_frame();
        tick(24);
        chk("pre_reset_digit2", {12'b0, anodes_n}, 16'h000B);
        reset    = 1'b1;
        load     = 1'b1;
        value_in = 16'hDEAD;
        dp_in    = 4'hF;
        mon_en   = 1'b0;
        exp_q.delete();
        tick(1);
        chk("midreset_anodes", {12'b0, anodes_n}, 16'h000F);
        chk("midreset_segments", {9'b0, segments_n}, 16'h007F);
        chk("midreset_dp", {15'b0, dp_n}, 16'h0001);
        chk("midreset_state", {15'b0, dbg_state}, {15'b0, BLANK});
        tick(1);
        reset    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        mon_en   = 1'b1;
        act_v = '0; act_dp = '0; pend_v = '0; pend_dp = '0;
        push_frame();

        wait_frame(); new_frame();
        n = 0;
        while (exp_q.size() > 0 && n < 2*FRAME) begin
            tick(1);
            n++;
        end
        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
